// File: rtl/skin_region_tracker_pkg.sv
// rtl/skin_region_tracker_pkg.sv - shared FSM states and default geometry for the skin region tracker
package skin_region_tracker_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam int unsigned DEF_IMG_WIDTH     = 320;
  localparam int unsigned DEF_IMG_HEIGHT    = 240;
  localparam int unsigned DEF_X_W           = 9;
  localparam int unsigned DEF_Y_W           = 8;
  localparam int unsigned DEF_CNT_W         = 10;
  localparam int unsigned DEF_MIN_ROW_COUNT = 4;

endpackage

// File: rtl/skin_region_tracker_row_accumulator.sv
// rtl/skin_region_tracker_row_accumulator.sv - per-row skin count, extent and column position
module row_accumulator #(
  parameter int unsigned IMG_WIDTH = 320,
  parameter int unsigned X_W       = 9,
  parameter int unsigned CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             beat_i,
  input  logic             start_i,
  input  logic             pix_bin_i,
  input  logic             eol_i,
  output logic [CNT_W-1:0] row_cnt_o,
  output logic [X_W-1:0]   row_x_first_o,
  output logic [X_W-1:0]   row_x_last_o,
  output logic             row_has_skin_o,
  output logic             pos_ovf_o,
  output logic             len_bad_o
);

  // Position is one bit wider than the column so "one past the last pixel" is representable.
  localparam int unsigned    P_W      = X_W + 1;
  localparam logic [P_W-1:0] POS_LAST = P_W'(IMG_WIDTH - 1);
  localparam logic [P_W-1:0] POS_SAT  = P_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(IMG_WIDTH);
  localparam logic [X_W-1:0] X_LAST   = X_W'(IMG_WIDTH - 1);

  logic [P_W-1:0]   pos_q, pos_d, cur_pos;
  logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;
  logic [X_W-1:0]   first_q, first_d, last_q, last_d, base_last, cur_x;
  logic             have_q, have_d, base_have;

  // Row summary including the current beat; a start-of-frame beat ignores any stale row state.
  always_comb begin
    cur_pos   = start_i ? '0 : pos_q;
    base_cnt  = start_i ? '0 : cnt_q;
    base_have = start_i ? 1'b0 : have_q;
    base_last = start_i ? '0 : last_q;
    cur_x     = (cur_pos == POS_SAT) ? X_LAST : cur_pos[X_W-1:0];

    row_cnt_o      = (base_cnt == CNT_SAT) ? CNT_SAT : base_cnt + CNT_W'(pix_bin_i);
    row_has_skin_o = base_have | pix_bin_i;
    row_x_first_o  = base_have ? first_q : cur_x;
    row_x_last_o   = pix_bin_i ? cur_x : base_last;
    pos_ovf_o      = beat_i & (cur_pos == POS_SAT);
    len_bad_o      = beat_i & eol_i & (cur_pos != POS_LAST);

    pos_d   = pos_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    last_d  = last_q;
    have_d  = have_q;
    if (beat_i) begin
      if (eol_i) begin
        pos_d   = '0;
        cnt_d   = '0;
        first_d = '0;
        last_d  = '0;
        have_d  = 1'b0;
      end else begin
        pos_d   = (cur_pos == POS_SAT) ? POS_SAT : cur_pos + P_W'(1);
        cnt_d   = row_cnt_o;
        first_d = row_x_first_o;
        last_d  = row_x_last_o;
        have_d  = row_has_skin_o;
      end
    end
  end

  // Row state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      have_q  <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
      have_q  <= have_d;
    end
  end

endmodule

// File: rtl/skin_region_tracker.sv
// rtl/skin_region_tracker.sv - frame-level bounding box / peak row tracker over a binary skin stream
module skin_region_tracker
  import skin_region_tracker_pkg::*;
#(
  parameter int unsigned IMG_WIDTH     = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT    = DEF_IMG_HEIGHT,
  parameter int unsigned X_W           = DEF_X_W,
  parameter int unsigned Y_W           = DEF_Y_W,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned MIN_ROW_COUNT = DEF_MIN_ROW_COUNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic             pix_bin,
  input  logic             pix_sof,
  input  logic             pix_eol,
  output logic             res_valid,
  output logic             res_found,
  output logic [X_W-1:0]   res_x_min,
  output logic [X_W-1:0]   res_x_max,
  output logic [Y_W-1:0]   res_y_min,
  output logic [Y_W-1:0]   res_y_max,
  output logic [Y_W-1:0]   res_peak_y,
  output logic [CNT_W-1:0] res_peak_cnt,
  output logic             res_err
);

  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] HIT_MIN = CNT_W'(MIN_ROW_COUNT);

  state_e state_q, state_d;
  logic   beat, start;

  logic [CNT_W-1:0] row_cnt;
  logic [X_W-1:0]   row_first, row_last;
  logic             row_has_skin, row_ovf, row_len_bad;

  logic [Y_W-1:0]   y_q, y_d, y_min_q, y_min_d, y_max_q, y_max_d, peak_y_q, peak_y_d;
  logic [X_W-1:0]   x_min_q, x_min_d, x_max_q, x_max_d;
  logic [CNT_W-1:0] peak_cnt_q, peak_cnt_d;
  logic             hit_q, hit_d, err_q, err_d;

  logic             res_valid_q, res_valid_d, res_found_q, res_found_d, res_err_q, res_err_d;
  logic [X_W-1:0]   res_x_min_q, res_x_min_d, res_x_max_q, res_x_max_d;
  logic [Y_W-1:0]   res_y_min_q, res_y_min_d, res_y_max_q, res_y_max_d, res_peak_y_q, res_peak_y_d;
  logic [CNT_W-1:0] res_peak_cnt_q, res_peak_cnt_d;

  // Outside a frame only a start-of-frame beat is taken; any SOF restarts the frame.
  assign start = pix_valid & pix_sof;
  assign beat  = pix_valid & (pix_sof | (state_q == ST_ACTIVE));

  row_accumulator #(
    .IMG_WIDTH (IMG_WIDTH),
    .X_W       (X_W),
    .CNT_W     (CNT_W)
  ) u_row (
    .clk            (clk),
    .reset          (reset),
    .beat_i         (beat),
    .start_i        (start),
    .pix_bin_i      (pix_bin),
    .eol_i          (pix_eol),
    .row_cnt_o      (row_cnt),
    .row_x_first_o  (row_first),
    .row_x_last_o   (row_last),
    .row_has_skin_o (row_has_skin),
    .pos_ovf_o      (row_ovf),
    .len_bad_o      (row_len_bad)
  );

  // Next state: frame restart, row merge on EOL, result load and FSM return on the last row.
  always_comb begin
    state_d        = state_q;
    y_d            = y_q;
    hit_d          = hit_q;
    x_min_d        = x_min_q;
    x_max_d        = x_max_q;
    y_min_d        = y_min_q;
    y_max_d        = y_max_q;
    peak_y_d       = peak_y_q;
    peak_cnt_d     = peak_cnt_q;
    err_d          = err_q;
    res_valid_d    = 1'b0;
    res_found_d    = res_found_q;
    res_x_min_d    = res_x_min_q;
    res_x_max_d    = res_x_max_q;
    res_y_min_d    = res_y_min_q;
    res_y_max_d    = res_y_max_q;
    res_peak_y_d   = res_peak_y_q;
    res_peak_cnt_d = res_peak_cnt_q;
    res_err_d      = res_err_q;

    if (beat) begin
      if (start) begin
        state_d    = ST_ACTIVE;
        y_d        = '0;
        hit_d      = 1'b0;
        x_min_d    = '0;
        x_max_d    = '0;
        y_min_d    = '0;
        y_max_d    = '0;
        peak_y_d   = '0;
        peak_cnt_d = '0;
        err_d      = 1'b0;
      end

      if (row_ovf || row_len_bad) begin
        err_d = 1'b1;
      end

      if (pix_eol) begin
        if (row_has_skin && (row_cnt >= HIT_MIN)) begin
          if (!hit_d) begin
            y_min_d = y_d;
            x_min_d = row_first;
            x_max_d = row_last;
          end else begin
            if (row_first < x_min_d) x_min_d = row_first;
            if (row_last > x_max_d)  x_max_d = row_last;
          end
          hit_d   = 1'b1;
          y_max_d = y_d;
          // Strictly greater: on a tie the earlier row keeps the peak.
          if (row_cnt > peak_cnt_d) begin
            peak_cnt_d = row_cnt;
            peak_y_d   = y_d;
          end
        end

        if (y_d == Y_LAST) begin
          res_valid_d    = 1'b1;
          res_found_d    = hit_d;
          res_x_min_d    = x_min_d;
          res_x_max_d    = x_max_d;
          res_y_min_d    = y_min_d;
          res_y_max_d    = y_max_d;
          res_peak_y_d   = peak_y_d;
          res_peak_cnt_d = peak_cnt_d;
          res_err_d      = err_d;
          state_d        = ST_IDLE;
          y_d            = '0;
        end else begin
          y_d = y_d + Y_W'(1);
        end
      end
    end
  end

  // Frame accumulators, FSM state and held result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      y_q            <= '0;
      hit_q          <= 1'b0;
      x_min_q        <= '0;
      x_max_q        <= '0;
      y_min_q        <= '0;
      y_max_q        <= '0;
      peak_y_q       <= '0;
      peak_cnt_q     <= '0;
      err_q          <= 1'b0;
      res_valid_q    <= 1'b0;
      res_found_q    <= 1'b0;
      res_x_min_q    <= '0;
      res_x_max_q    <= '0;
      res_y_min_q    <= '0;
      res_y_max_q    <= '0;
      res_peak_y_q   <= '0;
      res_peak_cnt_q <= '0;
      res_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      y_q            <= y_d;
      hit_q          <= hit_d;
      x_min_q        <= x_min_d;
      x_max_q        <= x_max_d;
      y_min_q        <= y_min_d;
      y_max_q        <= y_max_d;
      peak_y_q       <= peak_y_d;
      peak_cnt_q     <= peak_cnt_d;
      err_q          <= err_d;
      res_valid_q    <= res_valid_d;
      res_found_q    <= res_found_d;
      res_x_min_q    <= res_x_min_d;
      res_x_max_q    <= res_x_max_d;
      res_y_min_q    <= res_y_min_d;
      res_y_max_q    <= res_y_max_d;
      res_peak_y_q   <= res_peak_y_d;
      res_peak_cnt_q <= res_peak_cnt_d;
      res_err_q      <= res_err_d;
    end
  end

  assign res_valid    = res_valid_q;
  assign res_found    = res_found_q;
  assign res_x_min    = res_x_min_q;
  assign res_x_max    = res_x_max_q;
  assign res_y_min    = res_y_min_q;
  assign res_y_max    = res_y_max_q;
  assign res_peak_y   = res_peak_y_q;
  assign res_peak_cnt = res_peak_cnt_q;
  assign res_err      = res_err_q;

endmodule

// File: tb/tb_skin_region_tracker.sv
// tb/tb_skin_region_tracker.sv - self-checking bench for skin_region_tracker with a frame-level model
module tb_skin_region_tracker;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int MINC = 2;
  localparam int XW   = 3;
  localparam int YW   = 2;
  localparam int CW   = 4;

  typedef struct packed {
    logic          found;
    logic [XW-1:0] xmin;
    logic [XW-1:0] xmax;
    logic [YW-1:0] ymin;
    logic [YW-1:0] ymax;
    logic [YW-1:0] peaky;
    logic [CW-1:0] pcnt;
    logic          err;
  } res_t;

  logic clk = 1'b0;
  logic reset, pix_valid, pix_bin, pix_sof, pix_eol;
  logic res_valid, res_found, res_err;
  logic [XW-1:0] res_x_min, res_x_max;
  logic [YW-1:0] res_y_min, res_y_max, res_peak_y;
  logic [CW-1:0] res_peak_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int vcount  = 0;

  logic [9:0] frm [H];
  int         len [H];
  res_t       got;

  skin_region_tracker #(
    .IMG_WIDTH     (W),
    .IMG_HEIGHT    (H),
    .X_W           (XW),
    .Y_W           (YW),
    .CNT_W         (CW),
    .MIN_ROW_COUNT (MINC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_valid    (pix_valid),
    .pix_bin      (pix_bin),
    .pix_sof      (pix_sof),
    .pix_eol      (pix_eol),
    .res_valid    (res_valid),
    .res_found    (res_found),
    .res_x_min    (res_x_min),
    .res_x_max    (res_x_max),
    .res_y_min    (res_y_min),
    .res_y_max    (res_y_max),
    .res_peak_y   (res_peak_y),
    .res_peak_cnt (res_peak_cnt),
    .res_err      (res_err)
  );

  always #5 clk = ~clk;

  always_comb got = {res_found, res_x_min, res_x_max, res_y_min, res_y_max, res_peak_y, res_peak_cnt, res_err};

  always @(negedge clk) if (res_valid === 1'b1) vcount++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  function automatic res_t mk(logic f, int xmn, int xmx, int ymn, int ymx, int py, int pc, logic e);
    res_t r;
    r.found = f;
    r.xmin  = XW'(xmn);
    r.xmax  = XW'(xmx);
    r.ymin  = YW'(ymn);
    r.ymax  = YW'(ymx);
    r.peaky = YW'(py);
    r.pcnt  = CW'(pc);
    r.err   = e;
    return r;
  endfunction

  // Whole-frame reference: per-row counts, hit rows, box over hit rows, earliest maximum row.
  function automatic res_t model();
    int  xmn = W, xmx = -1, ymn = 0, ymx = 0, py = 0, best = 0;
    bit  any = 0, e = 0;
    for (int y = 0; y < H; y++) begin
      int cnt = 0, lo = -1, hi = -1;
      for (int x = 0; x < len[y]; x++) begin
        if (frm[y][x]) begin
          int col = (x < W) ? x : W - 1;
          cnt++;
          if (lo < 0) lo = col;
          hi = col;
        end
      end
      if (cnt > W) cnt = W;
      if (len[y] != W) e = 1;
      if (cnt >= MINC) begin
        if (!any) ymn = y;
        any = 1;
        ymx = y;
        if (lo < xmn) xmn = lo;
        if (hi > xmx) xmx = hi;
        if (cnt > best) begin
          best = cnt;
          py   = y;
        end
      end
    end
    if (!any) return mk(1'b0, 0, 0, 0, 0, 0, 0, e);
    return mk(1'b1, xmn, xmx, ymn, ymx, py, best, e);
  endfunction

  task automatic drive(input logic v, input logic b, input logic s, input logic e);
    pix_valid = v;
    pix_bin   = b;
    pix_sof   = s;
    pix_eol   = e;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_bin   = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
  endtask

  task automatic set_rows(input logic [9:0] r0, input logic [9:0] r1, input logic [9:0] r2, input logic [9:0] r3);
    frm[0] = r0; frm[1] = r1; frm[2] = r2; frm[3] = r3;
    for (int i = 0; i < H; i++) len[i] = W;
  endtask

  // Streams the stored frame, stopping after max_beats; returns #1 after the last accepted edge.
  task automatic send_beats(input int max_beats, input bit gaps);
    int n = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < len[y]; x++) begin
        if (n >= max_beats) return;
        if (gaps && ($urandom_range(0, 3) == 0))
          drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drive(1'b1, frm[y][x], (y == 0) && (x == 0), x == len[y] - 1);
        n++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    n_tests++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
    n_tests++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_fields: got %h expected 0", got); end
  endtask

  task automatic test_basic();
    res_t exp = mk(1'b1, 1, 6, 1, 2, 2, 6, 1'b0);
    set_rows(10'b0, 10'b0000011100, 10'b0001111110, 10'b0);
    send_beats(1000, 1'b0);
    n_tests++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_n1: got %b expected 1", res_valid); end
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL basic_fields: got %h expected %h", got, exp); end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_n2: got %b expected 0", res_valid); end
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL basic_hold: got %h expected %h", got, exp); end
  endtask

  task automatic test_all_zero();
    set_rows(10'b0, 10'b0, 10'b0, 10'b0);
    send_beats(1000, 1'b1);
    n_tests++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid: got %b expected 1", res_valid); end
    n_tests++;
    if (got !== '0) begin n_fail++; $display("FAIL zero_fields: got %h expected 0", got); end
  endtask

  task automatic test_tie();
    res_t exp = mk(1'b1, 0, 7, 2, 3, 2, 5, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    set_rows(10'b0, 10'b0, 10'b0000011111, 10'b0011111000);
    send_beats(1000, 1'b0);
    n_tests++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL tie_valid: got %b expected 1", res_valid); end
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL tie_fields: got %h expected %h", got, exp); end
  endtask

  task automatic test_below_threshold();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    set_rows(10'b0, 10'b0010000000, 10'b0, 10'b0);
    send_beats(1000, 1'b0);
    n_tests++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL thresh_valid: got %b expected 1", res_valid); end
    n_tests++;
    if (got !== '0) begin n_fail++; $display("FAIL thresh_fields: got %h expected 0", got); end
  endtask

  task automatic test_sof_restart();
    int   v0;
    res_t exp = mk(1'b1, 1, 6, 1, 2, 2, 6, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    v0 = vcount;
    set_rows(10'b1111111111, 10'b1111111111, 10'b1111111111, 10'b0);
    send_beats(2 * W + 3, 1'b0);
    set_rows(10'b0, 10'b0000011100, 10'b0001111110, 10'b0);
    send_beats(1000, 1'b0);
    n_tests++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL restart_valid: got %b expected 1", res_valid); end
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL restart_fields: got %h expected %h", got, exp); end
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (vcount !== v0 + 1) begin n_fail++; $display("FAIL restart_count: got %0d results expected %0d", vcount - v0, 1); end
  endtask

  task automatic test_err_back_to_back();
    int   v0 = vcount;
    res_t exp_err   = mk(1'b1, 1, 6, 1, 2, 2, 6, 1'b1);
    res_t exp_clean = mk(1'b1, 1, 6, 1, 2, 2, 6, 1'b0);
    set_rows(10'b0, 10'b0000011100, 10'b0001111110, 10'b0);
    len[0] = 6;
    send_beats(1000, 1'b0);
    n_tests++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL err_valid: got %b expected 1", res_valid); end
    n_tests++;
    if (got !== exp_err) begin n_fail++; $display("FAIL err_fields: got %h expected %h", got, exp_err); end
    len[0] = W;
    send_beats(1000, 1'b0);
    n_tests++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", res_valid); end
    n_tests++;
    if (got !== exp_clean) begin n_fail++; $display("FAIL b2b_fields: got %h expected %h", got, exp_clean); end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (vcount !== v0 + 2) begin n_fail++; $display("FAIL b2b_count: got %0d results expected %0d", vcount - v0, 2); end
  endtask

  task automatic test_reset_midframe();
    int   v0 = vcount;
    res_t exp = mk(1'b1, 1, 6, 1, 2, 2, 6, 1'b0);
    set_rows(10'b0, 10'b0000011100, 10'b0001111110, 10'b0);
    send_beats(W + 4, 1'b0);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (vcount !== v0) begin n_fail++; $display("FAIL midreset_count: got %0d results expected 0", vcount - v0); end
    n_tests++;
    if (got !== '0) begin n_fail++; $display("FAIL midreset_fields: got %h expected 0", got); end
    send_beats(1000, 1'b0);
    n_tests++;
    if (got !== exp || res_valid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_recover: got %h valid %b expected %h valid 1", got, res_valid, exp);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      res_t exp;
      for (int y = 0; y < H; y++) begin
        frm[y] = 10'($urandom) & 10'($urandom | $urandom);
        len[y] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 10)) : W;
      end
      exp = model();
      send_beats(1000, 1'($urandom_range(0, 1)));
      n_tests++;
      if (res_valid !== 1'b1 || got !== exp) begin
        n_fail++; $display("FAIL random_frame_%0d: got %h valid %b expected %h valid 1", f, got, res_valid, exp);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_bin   = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
    test_reset();
    test_basic();
    test_all_zero();
    test_tie();
    test_below_threshold();
    test_sof_restart();
    test_err_back_to_back();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/skin_region_tracker.md
# skin_region_tracker

Streaming stage directly downstream of the per-pixel skin filter: consumes one binary filtered pixel per beat in raster order and accumulates per-row skin counts across a frame. At frame end it reports the bounding box of qualifying rows, the peak row and its count, and an error flag. The result is presented to the target-recognition control logic as a one-cycle-valid, held-stable result set.

## Interface
- IMG_WIDTH, 320, pixels per row
- IMG_HEIGHT, 240, rows per frame
- X_W, 9, column index width (≥ clog2(IMG_WIDTH))
- Y_W, 8, row index width (≥ clog2(IMG_HEIGHT))
- CNT_W, 10, per-row count width (≥ clog2(IMG_WIDTH+1))
- MIN_ROW_COUNT, 4, skin pixels a row needs to qualify as a hit row
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- pix_valid  in  1  beat qualifier; one pixel is accepted per cycle when high (no backpressure)
- pix_bin  in  1  filtered pixel, 1 = skin
- pix_sof  in  1  marks the first pixel of a frame
- pix_eol  in  1  marks the last pixel of a row
- res_valid  out  1  one-cycle pulse: result fields updated
- res_found  out  1  at least one hit row in the frame
- res_x_min, res_x_max  out  X_W  leftmost/rightmost skin column over hit rows
- res_y_min, res_y_max  out  Y_W  first/last hit row
- res_peak_y  out  Y_W  row with the largest count (ties → earliest row)
- res_peak_cnt  out  CNT_W  that row's count
- res_err  out  1  frame had a row-length mismatch

## Operation
- FSM: IDLE, ACTIVE. Reset → IDLE; all res_* outputs and internal accumulators = 0.
- IDLE: beats without pix_sof are dropped. A beat with pix_sof → clear frame accumulators, process it as x=0, y=0, go ACTIVE.
- ACTIVE, each beat: row_cnt += pix_bin, saturating at IMG_WIDTH. On the first skin pixel of the row, capture row_x_first; on every skin pixel, update row_x_last. x increments, saturating at IMG_WIDTH-1; beats past that point still count toward row_cnt (saturated) and set err.
- Row close on pix_eol beat (the current pixel is included): err set if x ≠ IMG_WIDTH-1. If row_cnt ≥ MIN_ROW_COUNT the row is a hit: first hit sets y_min; every hit sets y_max and merges row_x_first/row_x_last into x_min/x_max. A row becomes the peak if row_cnt > peak_cnt, so ties keep the earlier row. Then clear the row state, x=0, y+1.
- Frame close: pix_eol while y = IMG_HEIGHT-1 → load res_* from accumulators (res_found = any hit row; box/peak fields 0 when none), pulse res_valid, go IDLE.
- pix_sof while ACTIVE: partial frame discarded, no result, restart as from IDLE on that beat.
- pix_sof and pix_eol on the same beat: handled as SOF then EOL for a one-pixel row.
- Reset mid-frame: accumulators cleared, IDLE, no result.

## Timing
- Final pix_eol beat accepted in cycle N → res_valid high in cycle N+1 only; res_* valid from N+1 and held until the next res_valid or reset.
- A new frame's pix_sof is accepted in cycle N+1; back-to-back frames lose no beats.
- Throughput 1 pixel/cycle; no ready signal.

## Structure
- Shared package/header: FSM state encodings, default width constants.
- One natural sub-module, row_accumulator: holds row_cnt, row_x_first, row_x_last and x, and presents the row summary on the eol beat. Frame merge and FSM sit in the top.

## Test plan
Bench parameters: IMG_WIDTH=8, IMG_HEIGHT=4, MIN_ROW_COUNT=2.
- Frame rows 00000000 / 00111000 / 01111110 / 00000000 → res_valid one cycle after the last eol; found=1, x 1..6, y 1..2, peak_y=2, peak_cnt=6, err=0.
- All-zero frame → found=0, all box/peak fields 0, err=0.
- Rows 2 and 3 both count 5 → peak_y=2 (tie keeps the earlier row).
- Row 1 has a single skin pixel at x=7, other rows empty → found=0 (below threshold).
- pix_sof injected mid-row 2, then a full clean frame → exactly one res_valid, for the clean frame only.
- Row 0 eol at x=5, rest correct → err=1; next clean frame → err=0. A back-to-back SOF in cycle N+1 is accepted with no lost beat.
